// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the Guia 04 truth-table sweep blocks:
// sweep FSM state encoding, row count and index/counter widths.
package guia04_pkg;

  localparam int ROWS   = 16;
  localparam int IDX_W  = 4;
  localparam int CNT_W  = 4;
  localparam int MCNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Connection between the sweeper and the block it exercises/captures.
// Handshake: start is a one-cycle request, honoured only while busy=0;
// done pulses for exactly one cycle at sweep end, and the tables and flags
// are stable from that cycle until the next accepted start or reset.
interface truth_table_sweeper_if;
  import guia04_pkg::*;

  logic                start;
  logic                sop_in;
  logic                pos_in;
  logic                x;
  logic                y;
  logic                w;
  logic                z;
  logic                busy;
  logic                done;
  logic [ROWS-1:0]     sop_table;
  logic [ROWS-1:0]     pos_table;
  logic                mismatch;
  logic [MCNT_W-1:0]   mismatch_count;
  logic [IDX_W-1:0]    first_mismatch;
  state_t              state;

  // Side that requests sweeps and hosts the expression block.
  modport master (
    output start, sop_in, pos_in,
    input  x, y, w, z, busy, done, sop_table, pos_table,
           mismatch, mismatch_count, first_mismatch, state
  );

  // The sweeper itself.
  modport slave (
    input  start, sop_in, pos_in,
    output x, y, w, z, busy, done, sop_table, pos_table,
           mismatch, mismatch_count, first_mismatch, state
  );
endinterface

// File: rtl/truth_table_sweeper_settle_counter.sv
// 4-bit settle counter with clear/enable. term is high while the count
// equals SETTLE-1, i.e. on the last settle cycle of a row.
module settle_counter
  import guia04_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(SETTLE - 1);

  // Count settle cycles; clear wins over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign term = (count == TERM_VAL);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks {x,y,w,z} through rows 0..F, holds each row SETTLE cycles, then
// samples the SoP/PoS outputs of the block under test into truth tables
// and records any rows where the two forms disagree.
// SETTLE legal range is 1..15.
module truth_table_sweeper
  import guia04_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  truth_table_sweeper_if.slave  bus
);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic                busy_r;
  logic                done_r;
  logic [ROWS-1:0]     sop_tab;
  logic [ROWS-1:0]     pos_tab;
  logic                mm_flag;
  logic [MCNT_W-1:0]   mm_count;
  logic [IDX_W-1:0]    mm_first;

  logic                cnt_clear;
  logic                cnt_en;
  logic                cnt_term;
  logic [CNT_W-1:0]    cnt_value;

  // Restart the settle count on sweep start and on every row advance.
  assign cnt_clear = ((state == S_IDLE) && bus.start) || (state == S_SAMPLE);
  assign cnt_en    = (state == S_APPLY);

  settle_counter #(.SETTLE(SETTLE)) u_settle (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (cnt_value),
    .term   (cnt_term)
  );

  // Sweep FSM with all outputs registered; reset aborts a sweep at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      sop_tab  <= '0;
      pos_tab  <= '0;
      mm_flag  <= 1'b0;
      mm_count <= '0;
      mm_first <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          busy_r <= 1'b0;
          if (bus.start) begin
            sop_tab  <= '0;
            pos_tab  <= '0;
            mm_flag  <= 1'b0;
            mm_count <= '0;
            mm_first <= '0;
            idx      <= '0;
            busy_r   <= 1'b1;
            state    <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (cnt_term) begin
            state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          sop_tab[idx] <= bus.sop_in;
          pos_tab[idx] <= bus.pos_in;
          if (bus.sop_in != bus.pos_in) begin
            mm_count <= mm_count + 1'b1;
            if (!mm_flag) begin
              mm_flag  <= 1'b1;
              mm_first <= idx;
            end
          end
          if (idx == IDX_W'(ROWS - 1)) begin
            done_r <= 1'b1;
            state  <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_APPLY;
          end
        end
        S_DONE: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.x              = idx[3];
  assign bus.y              = idx[2];
  assign bus.w              = idx[1];
  assign bus.z              = idx[0];
  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.sop_table      = sop_tab;
  assign bus.pos_table      = pos_tab;
  assign bus.mismatch       = mm_flag;
  assign bus.mismatch_count = mm_count;
  assign bus.first_mismatch = mm_first;
  assign bus.state          = state;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: one instance with SETTLE=1 and one with
// SETTLE=3, each driving a table-defined expression block model.
module tb_truth_table_sweeper;

  logic clk;
  logic reset;

  int vectors;
  int miscompares;

  // Truth tables of the modelled expression block: bit r = output on row r.
  logic [15:0] sop_tt;
  logic [15:0] pos_tt;

  truth_table_sweeper_if if0 ();
  truth_table_sweeper_if if1 ();

  truth_table_sweeper #(.SETTLE(1)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  truth_table_sweeper #(.SETTLE(3)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- expression block models ----------------
  logic [3:0] row_v [2];
  logic       start_v [2];
  logic       busy_v [2];
  logic       done_v [2];
  logic       mm_v [2];
  logic [4:0] cnt_v [2];
  logic [3:0] first_v [2];
  logic [15:0] st_v [2];
  logic [15:0] pt_v [2];

  assign row_v[0]   = {if0.x, if0.y, if0.w, if0.z};
  assign row_v[1]   = {if1.x, if1.y, if1.w, if1.z};
  assign busy_v[0]  = if0.busy;
  assign busy_v[1]  = if1.busy;
  assign done_v[0]  = if0.done;
  assign done_v[1]  = if1.done;
  assign mm_v[0]    = if0.mismatch;
  assign mm_v[1]    = if1.mismatch;
  assign cnt_v[0]   = if0.mismatch_count;
  assign cnt_v[1]   = if1.mismatch_count;
  assign first_v[0] = if0.first_mismatch;
  assign first_v[1] = if1.first_mismatch;
  assign st_v[0]    = if0.sop_table;
  assign st_v[1]    = if1.sop_table;
  assign pt_v[0]    = if0.pos_table;
  assign pt_v[1]    = if1.pos_table;
  assign if0.start  = start_v[0];
  assign if1.start  = start_v[1];

  always_comb begin
    if0.sop_in = sop_tt[row_v[0]];
    if0.pos_in = pos_tt[row_v[0]];
    if1.sop_in = sop_tt[row_v[1]];
    if1.pos_in = pos_tt[row_v[1]];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: results follow directly from the two truth tables.
  task automatic check_model(input int d, input string tag);
    logic [15:0] diff;
    int          exp_cnt;
    int          exp_first;
    diff      = sop_tt ^ pos_tt;
    exp_cnt   = 0;
    exp_first = -1;
    for (int r = 0; r < 16; r++) begin
      if (diff[r]) begin
        exp_cnt++;
        if (exp_first < 0) exp_first = r;
      end
    end
    check({tag, "_sop_table"}, 32'(st_v[d]), 32'(sop_tt));
    check({tag, "_pos_table"}, 32'(pt_v[d]), 32'(pos_tt));
    check({tag, "_mismatch"}, 32'(mm_v[d]), 32'(exp_cnt != 0));
    check({tag, "_mm_count"}, 32'(cnt_v[d]), 32'(exp_cnt));
    if (exp_cnt != 0) check({tag, "_first_mm"}, 32'(first_v[d]), 32'(exp_first));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Pulse start, optionally re-pulse at restart_at, wait for done.
  task automatic run_sweep(input int d, input int settle, input int exp_done,
                           input int restart_at, input bit check_rows,
                           input string tag);
    int cyc;
    @(negedge clk);
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    cyc = 1;
    while (!done_v[d] && cyc < 400) begin
      if (check_rows && cyc <= 16 * (settle + 1))
        check({tag, "_row"}, 32'(row_v[d]), 32'((cyc - 1) / (settle + 1)));
      start_v[d] = (cyc == restart_at);
      @(negedge clk);
      cyc++;
    end
    start_v[d] = 1'b0;
    check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_done));
    check({tag, "_busy_at_done"}, 32'(busy_v[d]), 32'd1);
    check({tag, "_row_at_done"}, 32'(row_v[d]), 32'd15);
    check_model(d, tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done_v[d]), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy_v[d]), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          got_q[$];
    logic [31:0] exp_q[$];
    int          cyc;

    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    start_v[0]  = 1'b0;
    start_v[1]  = 1'b0;
    sop_tt      = '0;
    pos_tt      = '0;

    // Reset state
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_busy", 32'(busy_v[d]), 32'd0);
      check("rst_done", 32'(done_v[d]), 32'd0);
      check("rst_row", 32'(row_v[d]), 32'd0);
      check("rst_sop_table", 32'(st_v[d]), 32'd0);
      check("rst_pos_table", 32'(pt_v[d]), 32'd0);
      check("rst_mismatch", 32'(mm_v[d]), 32'd0);
      check("rst_mm_count", 32'(cnt_v[d]), 32'd0);
      check("rst_first_mm", 32'(first_v[d]), 32'd0);
    end
    reset = 1'b0;

    // Parity model: both forms = x^y^w^z
    for (int r = 0; r < 16; r++) begin
      logic [3:0] rr;
      rr = 4'(r);
      sop_tt[r] = ^rr;
    end
    pos_tt = sop_tt;
    run_sweep(0, 1, 33, 0, 1'b1, "parity");
    check("parity_const", 32'(st_v[0]), 32'h6996);

    // Single fault: sop = x&y, pos inverted on row 5
    for (int r = 0; r < 16; r++) sop_tt[r] = (r >= 12);
    pos_tt = sop_tt;
    pos_tt[5] = ~pos_tt[5];
    run_sweep(0, 1, 33, 0, 1'b0, "single");
    check("single_sop_const", 32'(st_v[0]), 32'hF000);
    check("single_pos_const", 32'(pt_v[0]), 32'hF020);

    // Multiple faults on rows 3, 9, E over a random table
    sop_tt = 16'($urandom);
    pos_tt = sop_tt;
    pos_tt[3]  = ~pos_tt[3];
    pos_tt[9]  = ~pos_tt[9];
    pos_tt[14] = ~pos_tt[14];
    run_sweep(0, 1, 33, 0, 1'b0, "multi");

    // Random tables
    for (int k = 0; k < 4; k++) begin
      sop_tt = 16'($urandom);
      pos_tt = ($urandom_range(0, 1) == 1) ? sop_tt : 16'($urandom);
      run_sweep(0, 1, 33, 0, 1'b0, "random");
    end

    // Settle timing on the SETTLE=3 instance
    sop_tt = 16'($urandom);
    pos_tt = 16'($urandom);
    run_sweep(1, 3, 65, 0, 1'b1, "settle3");

    // Start while busy is ignored
    sop_tt = 16'($urandom);
    pos_tt = sop_tt ^ 16'($urandom_range(0, 65535));
    run_sweep(0, 1, 33, 10, 1'b1, "busy_start");

    // Start held high for 70 cycles: back-to-back sweeps
    exp_q.push_back(32'd33);
    exp_q.push_back(32'd67);
    @(negedge clk);
    start_v[0] = 1'b1;
    cyc = 0;
    while (cyc < 69) begin
      @(negedge clk);
      cyc++;
      if (done_v[0]) got_q.push_back(cyc);
    end
    start_v[0] = 1'b0;
    check("hold_done_count", 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check("hold_done_cycle", 32'(got_q.pop_front()), exp_q.pop_front());
    do_reset();

    // Reset mid-sweep at cycle 20
    for (int r = 0; r < 16; r++) begin
      logic [3:0] rr;
      rr = 4'(r);
      sop_tt[r] = ^rr;
    end
    pos_tt = ~sop_tt;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    cyc = 1;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_busy_before", 32'(busy_v[0]), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 32'(busy_v[0]), 32'd0);
    check("midrst_row", 32'(row_v[0]), 32'd0);
    check("midrst_sop_table", 32'(st_v[0]), 32'd0);
    check("midrst_pos_table", 32'(pt_v[0]), 32'd0);
    check("midrst_mismatch", 32'(mm_v[0]), 32'd0);
    check("midrst_mm_count", 32'(cnt_v[0]), 32'd0);
    repeat (3) @(negedge clk);
    check("midrst_stays_idle", 32'(busy_v[0]), 32'd0);
    run_sweep(0, 1, 33, 0, 1'b0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture stage that sits directly upstream and downstream of the 4-input SoP/PoS expression blocks of Guia 04.
- Drives x,y,w,z through all 16 rows, 0 to F, in order, and waits a programmable settle time on each row.
- Samples the block's SoP and PoS outputs into 16-bit truth-table registers.
- Flags any row where the SoP and PoS forms disagree.
- Replaces hand-written per-row stimulus with a synthesizable, self-checking sweep.

Parameters:
- SETTLE, default 1: cycles each row is held before sampling; legal range 1..15.
- ROWS, default 16: number of input combinations; fixed by the 4-bit input width and not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep.
- sop_in  input  1  SoP output (s1) of the expression block under test.
- pos_in  input  1  PoS output (s2) of the expression block under test.
- x  output  1  row index bit 3 (MSB).
- y  output  1  row index bit 2.
- w  output  1  row index bit 1.
- z  output  1  row index bit 0 (LSB).
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- sop_table  output  16  bit i = sop_in sampled on row i.
- pos_table  output  16  bit i = pos_in sampled on row i.
- mismatch  output  1  sticky; set if any row had sop_in != pos_in.
- mismatch_count  output  5  number of disagreeing rows, 0..16.
- first_mismatch  output  4  index of the lowest disagreeing row; valid only when mismatch=1.

Behaviour:
- Reset values, applied on a clk edge with reset=1:
  - state=IDLE; x,y,w,z=0; busy=0; done=0.
  - sop_table=0, pos_table=0.
  - mismatch=0, mismatch_count=0, first_mismatch=0.
- Reset has priority over everything, including a reset asserted mid-sweep. The sweep aborts and the next cycle is IDLE with all outputs at their reset values.
- Row index is {x,y,w,z}, held in one 4-bit register idx. Row number equals the Guia row label (0..F).
- IDLE:
  - busy=0.
  - start=1 → clear both tables, mismatch, mismatch_count and first_mismatch; set idx=0 and settle counter=0; next state is APPLY.
- APPLY:
  - busy=1; idx is stable on x,y,w,z.
  - The settle counter increments each cycle.
  - When it reaches SETTLE-1, the next state is SAMPLE.
- SAMPLE (one cycle):
  - sop_table[idx]<=sop_in; pos_table[idx]<=pos_in.
  - If sop_in!=pos_in: mismatch_count increments. If mismatch was 0, first_mismatch<=idx and mismatch<=1.
  - If idx==15 → next state is DONE. Otherwise idx<=idx+1, settle counter resets to 0, and the next state is APPLY.
- DONE (one cycle):
  - done=1, busy=1; idx stays at 15.
  - Next state is IDLE.
- Latency: done is high in cycle 16*(SETTLE+1)+1 after the start cycle, with the start cycle counted as cycle 0. Per-row hold is SETTLE+1 cycles. For SETTLE=1, done is at cycle 33.
- Boundary conditions:
  - start while busy=1 (APPLY, SAMPLE or DONE) is ignored, with no restart and no table clear.
  - start held high continuously starts a new sweep on the IDLE cycle after DONE.
  - idx never wraps during a sweep. The 15→0 transition happens only through a new start.
  - Tables and flags hold their values in IDLE until the next start or reset.
  - mismatch_count saturates naturally at 16, so 5 bits suffice.
- x,y,w,z are registered outputs, so the expression block sees a glitch-free row change.

Decomposition:
- Shared package guia04_pkg:
  - State encoding localparams S_IDLE, S_APPLY, S_SAMPLE, S_DONE (2 bits).
  - ROWS=16 and IDX_W=4.
- One natural sub-module, settle_counter: a 4-bit counter with clear/enable that asserts a terminal flag at SETTLE-1. It is reused by later Guia sweeps.
- Everything else stays in truth_table_sweeper.

Test Plan:
- Parity model: SETTLE=1, with sop_in and pos_in both driven as x^y^w^z. Pulse start. Required: done at cycle 33; sop_table=pos_table=16'h6996; mismatch=0; mismatch_count=0.
- Single fault: sop_in = x&y, and pos_in equals sop_in except inverted on row 5. Required: sop_table=16'hF000, pos_table=16'hF020, mismatch=1, mismatch_count=1, first_mismatch=4'h5.
- Multiple faults: pos_in = ~sop_in on rows 3, 9 and E. Required: mismatch_count=3 and first_mismatch=3.
- Settle timing: SETTLE=3. Required: each row is held on x,y,w,z for exactly 4 cycles; done at cycle 65; row order is 0,1,…,F.
- Start while busy: pulse start again at cycle 10 of a sweep. Required: no restart and done still at cycle 33. Separately, hold start high for 70 cycles. Required: back-to-back sweeps, with the second done at cycle 67.
- Reset mid-sweep: assert reset at cycle 20. Required: the next cycle shows busy=0, x,y,w,z=0 and tables=0. A fresh start then completes normally.
